// File: rtl/seg_pkg.sv
// seg_pkg: FSM state type and seven-segment glyphs shared by seg_scan_display and its converter.
// Segment order is {dp,g,f,e,d,c,b,a}, active-high.
package seg_pkg;
    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_e;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    function automatic logic [7:0] seg_glyph(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0: g = 8'h3F;
            4'h1: g = 8'h06;
            4'h2: g = 8'h5B;
            4'h3: g = 8'h4F;
            4'h4: g = 8'h66;
            4'h5: g = 8'h6D;
            4'h6: g = 8'h7D;
            4'h7: g = 8'h07;
            4'h8: g = 8'h7F;
            4'h9: g = 8'h6F;
            4'hA: g = 8'h77;
            4'hB: g = 8'h7C;
            4'hC: g = 8'h39;
            4'hD: g = 8'h5E;
            4'hE: g = 8'h79;
            default: g = 8'h71;
        endcase
        return g;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble; start loads value, then one shift-add-3 step per cycle for VAL_W cycles.
// done flags the final step; bcd holds the result from the following cycle until the next start.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int VAL_W = 16,
    parameter int NDIG  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [VAL_W-1:0]  value,
    output logic              done,
    output logic [4*NDIG-1:0] bcd
);
    localparam int CW = $clog2(VAL_W + 1);
    logic [VAL_W-1:0]  sh_q, sh_d;
    logic [4*NDIG-1:0] bcd_q, bcd_d, adj;
    logic [CW-1:0]     cnt_q, cnt_d;
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NDIG; i++)
            adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
        sh_d  = start ? value : (cnt_q != '0 ? sh_q << 1 : sh_q);
        bcd_d = start ? '0 : (cnt_q != '0 ? {adj[4*NDIG-2:0], sh_q[VAL_W-1]} : bcd_q);
        cnt_d = start ? CW'(VAL_W) : cnt_q - CW'(cnt_q != '0);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end
    assign done = cnt_q == CW'(1);
    assign bcd  = bcd_q;
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: latches a value over valid/ready, converts to hex or decimal glyphs, scans DIGITS digits.
// Build option LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int VAL_W    = 16,
    parameter int SCAN_DIV = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VAL_W-1:0]  in_value,
    input  logic              in_dec,
    output logic              busy,
    output logic              ovf,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] seg_sel
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    if (VAL_W > 4*DIGITS || DIGITS < 1 || DIGITS > 16 || SCAN_DIV < 2) begin : g_bad_params
        $error("seg_scan_display: need 1<=DIGITS<=16, VAL_W<=4*DIGITS, SCAN_DIV>=2");
    end
    state_e              state_q, state_d;
    logic [VAL_W-1:0]    val_q, val_d;
    logic                dec_q, dec_d, ovf_q, ovf_d, start, done, tick, nz;
    logic [8*DIGITS-1:0] bcd;
    logic [4*DIGITS-1:0] hex, nib;
    logic [7:0]          shadow_q [DIGITS];
    logic [7:0]          shadow_d [DIGITS];
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    assign start = state_q == IDLE && in_valid && in_dec;
    bin2bcd_seq #(.VAL_W(VAL_W), .NDIG(2*DIGITS)) u_conv (
        .clock(clock),
        .reset(reset),
        .start(start),
        .value(in_value),
        .done(done),
        .bcd(bcd)
    );
    assign hex = (4*DIGITS)'(val_q);
    assign nib = dec_q ? bcd[4*DIGITS-1:0] : hex;
    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        dec_d    = dec_q;
        ovf_d    = ovf_q;
        shadow_d = shadow_q;
        nz       = 1'b0;
        if (state_q == IDLE && in_valid) begin
            val_d   = in_value;
            dec_d   = in_dec;
            state_d = in_dec ? CONV : LOAD;
        end else if (state_q == CONV && done) begin
            state_d = LOAD;
        end else if (state_q == LOAD) begin
            state_d = IDLE;
            ovf_d   = dec_q && |bcd[8*DIGITS-1:4*DIGITS];
            // Walk from the top digit down so nz marks "a nonzero digit at or above i".
            for (int i = DIGITS - 1; i >= 0; i--) begin
                nz          = nz | (nib[4*i+:4] != 4'd0);
                shadow_d[i] = ovf_d ? SEG_DASH : seg_glyph(nib[4*i+:4]);
`ifdef LEADING_ZERO_BLANK_EN
                if (!ovf_d && !nz && i != 0) shadow_d[i] = SEG_BLANK;
`endif
            end
        end
    end
    assign tick = cnt_q == CW'(SCAN_DIV - 1);
    // An all-zero select marks the first tick after reset, which lights digit 0 without advancing.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        sel_d = sel_q;
        seg_d = seg_q;
        if (tick) begin
            idx_d = sel_q == '0 ? '0 : (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1));
            sel_d = DIGITS'(1) << idx_d;
            seg_d = shadow_q[idx_d];
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            val_q    <= '0;
            dec_q    <= 1'b0;
            ovf_q    <= 1'b0;
            shadow_q <= '{default: SEG_BLANK};
            cnt_q    <= '0;
            idx_q    <= '0;
            seg_q    <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            val_q    <= val_d;
            dec_q    <= dec_d;
            ovf_q    <= ovf_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            sel_q    <= sel_d;
        end
    end
    assign in_ready = state_q == IDLE;
    assign busy     = state_q == CONV;
    assign ovf      = ovf_q;
    assign seg      = seg_q;
    assign seg_sel  = sel_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: 8-digit and 4-digit instances driven in lockstep, checked against an arithmetic display model.
// Honors LEADING_ZERO_BLANK_EN the same way the design does.
module tb_seg_scan_display;
    logic        clock = 1'b0, reset = 1'b0, in_valid = 1'b0, in_dec = 1'b0;
    logic [15:0] in_value = '0;
    logic        rdy8, rdy4, busy8, busy4, ovf8, ovf4;
    logic [7:0]  seg8, seg4, sel8;
    logic [3:0]  sel4;
    logic [7:0]  disp8 [8];
    logic [7:0]  disp4 [4];
    int          cmp = 0, bad = 0;
    localparam logic [7:0] GL [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                       8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    typedef struct { logic [15:0] v; bit d; bit o8; bit o4; logic [7:0] g8; logic [7:0] g4; } vec_t;
    vec_t tbl [6];

    always #5 clock = ~clock;

    seg_scan_display #(.DIGITS(8), .VAL_W(16), .SCAN_DIV(4)) u8 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy8), .in_value(in_value),
        .in_dec(in_dec), .busy(busy8), .ovf(ovf8), .seg(seg8), .seg_sel(sel8));
    seg_scan_display #(.DIGITS(4), .VAL_W(16), .SCAN_DIV(4)) u4 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy4), .in_value(in_value),
        .in_dec(in_dec), .busy(busy4), .ovf(ovf4), .seg(seg4), .seg_sel(sel4));

    function automatic bit m_ovf(int unsigned v, bit dec, int nd);
        longint p = 1;
        for (int i = 0; i < nd; i++) p *= 10;
        return dec && longint'(v) >= p;
    endfunction

    function automatic logic [7:0] m_glyph(int unsigned v, bit dec, int nd, int i);
        longint b = dec ? 10 : 16;
        longint p = 1;
        for (int k = 0; k < i; k++) p *= b;
        if (m_ovf(v, dec, nd)) return 8'h40;
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && longint'(v) < p) return 8'h00;
`endif
        return GL[int'((longint'(v) / p) % b)];
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(logic [15:0] v, bit d);
        int w = 0, lo = 0, bz = 0;
        while (!rdy8 && w < 200) begin
            @(negedge clock);
            w++;
        end
        chk("ready_wait", 32'(rdy8), 32'd1);
        in_valid = 1'b1;
        in_value = v;
        in_dec   = d;
        @(negedge clock);
        in_valid = 1'b0;
        while (!rdy8 && lo < 100) begin
            lo++;
            bz += int'(busy8);
            @(negedge clock);
        end
        chk($sformatf("ready_low_cycles v=%0h dec=%0b", v, d), lo, d ? 17 : 1);
        chk($sformatf("busy_cycles v=%0h dec=%0b", v, d), bz, d ? 16 : 0);
    endtask

    task automatic capture();
        foreach (disp8[i]) disp8[i] = 'x;
        foreach (disp4[i]) disp4[i] = 'x;
        repeat (8) @(negedge clock);
        repeat (40) begin
            @(negedge clock);
            for (int i = 0; i < 8; i++) if (sel8[i]) disp8[i] = seg8;
            for (int i = 0; i < 4; i++) if (sel4[i]) disp4[i] = seg4;
        end
    endtask

    task automatic check_display(logic [15:0] v, bit d);
        for (int i = 0; i < 8; i++)
            chk($sformatf("dig8[%0d] v=%0h dec=%0b", i, v, d), disp8[i], m_glyph(v, d, 8, i));
        for (int i = 0; i < 4; i++)
            chk($sformatf("dig4[%0d] v=%0h dec=%0b", i, v, d), disp4[i], m_glyph(v, d, 4, i));
        chk($sformatf("ovf8 v=%0h dec=%0b", v, d), 32'(ovf8), 32'(m_ovf(v, d, 8)));
        chk($sformatf("ovf4 v=%0h dec=%0b", v, d), 32'(ovf4), 32'(m_ovf(v, d, 4)));
    endtask

    initial begin
        int n;
        logic [15:0] v;
        bit d;
        tbl[0] = '{16'hBEEF, 1'b0, 1'b0, 1'b0, 8'h71, 8'h71};
        tbl[1] = '{16'd65535, 1'b1, 1'b0, 1'b1, 8'h6D, 8'h40};
        tbl[2] = '{16'd10000, 1'b1, 1'b0, 1'b1, 8'h3F, 8'h40};
        tbl[3] = '{16'h0001, 1'b0, 1'b0, 1'b0, 8'h06, 8'h06};
        tbl[4] = '{16'd0, 1'b1, 1'b0, 1'b0, 8'h3F, 8'h3F};
        tbl[5] = '{16'd9999, 1'b1, 1'b0, 1'b0, 8'h6F, 8'h6F};
        #1 reset = 1'b1;
        #2;
        chk("rst_ready", 32'({rdy8, rdy4}), 32'h3);
        chk("rst_busy", 32'({busy8, busy4}), 32'h0);
        chk("rst_ovf", 32'({ovf8, ovf4}), 32'h0);
        chk("rst_seg", 32'({seg8, seg4}), 32'h0);
        chk("rst_sel", 32'({sel8, sel4}), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            chk($sformatf("scan_sel8 k=%0d", k), 32'(sel8), k < 4 ? 32'h0 : 32'(1) << (((k / 4) - 1) % 8));
            chk($sformatf("scan_sel4 k=%0d", k), 32'(sel4), k < 4 ? 32'h0 : 32'(1) << (((k / 4) - 1) % 4));
        end
        foreach (tbl[i]) begin
            send(tbl[i].v, tbl[i].d);
            capture();
            check_display(tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d_ovf8", i), 32'(ovf8), 32'(tbl[i].o8));
            chk($sformatf("tbl%0d_ovf4", i), 32'(ovf4), 32'(tbl[i].o4));
            chk($sformatf("tbl%0d_dig8_0", i), 32'(disp8[0]), 32'(tbl[i].g8));
            chk($sformatf("tbl%0d_dig4_0", i), 32'(disp4[0]), 32'(tbl[i].g4));
        end
        in_valid = 1'b1;
        in_dec   = 1'b1;
        in_value = 16'd1234;
        @(negedge clock);
        n = 0;
        while (!rdy8 && n < 100) begin
            in_value = 16'($urandom);
            in_dec   = 1'($urandom_range(0, 1));
            n++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        chk("held_valid_latency", n, 17);
        repeat (3) @(negedge clock);
        chk("held_valid_no_extra_xfer", 32'({rdy8, busy8}), 32'h2);
        capture();
        check_display(16'd1234, 1'b1);
        in_valid = 1'b1;
        in_dec   = 1'b1;
        in_value = 16'd4321;
        @(negedge clock);
        n = 0;
        while (!rdy8 && n < 100) begin
            in_value = 16'($urandom);
            in_dec   = 1'($urandom_range(0, 1));
            n++;
            @(negedge clock);
        end
        in_value = 16'hA5C3;
        in_dec   = 1'b0;
        @(negedge clock);
        in_valid = 1'b0;
        chk("second_xfer_taken", 32'(rdy8), 32'h0);
        @(negedge clock);
        capture();
        check_display(16'hA5C3, 1'b0);
        in_valid = 1'b1;
        in_dec   = 1'b1;
        in_value = 16'd777;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (5) @(negedge clock);
        chk("busy_before_reset", 32'(busy8), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("midconv_rst_ready", 32'({rdy8, rdy4}), 32'h3);
        chk("midconv_rst_busy", 32'({busy8, busy4}), 32'h0);
        chk("midconv_rst_ovf", 32'({ovf8, ovf4}), 32'h0);
        chk("midconv_rst_seg", 32'({seg8, seg4}), 32'h0);
        chk("midconv_rst_sel", 32'({sel8, sel4}), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        capture();
        for (int i = 0; i < 8; i++) chk($sformatf("post_rst_dig8[%0d]", i), 32'(disp8[i]), 32'h0);
        for (int i = 0; i < 4; i++) chk($sformatf("post_rst_dig4[%0d]", i), 32'(disp4[i]), 32'h0);
        chk("post_rst_ovf", 32'({ovf8, ovf4}), 32'h0);
        for (int r = 0; r < 24; r++) begin
            v = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 99)) : 16'($urandom);
            d = 1'($urandom_range(0, 1));
            send(v, d);
            capture();
            check_display(v, d);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
